// File: rtl/peripheral_power_pkg.sv
// Shared power-management types: power node states and the peripheral clock-gate sequencer states.
package peripheral_power_pkg;

  typedef enum logic [1:0] {
    PWR_OFF      = 2'd0,
    PWR_STARTING = 2'd1,
    PWR_ON       = 2'd2,
    PWR_STOPPING = 2'd3
  } pwr_node_state_e;

  typedef enum logic [2:0] {
    PCG_RUN     = 3'd0,
    PCG_QUIESCE = 3'd1,
    PCG_GATE    = 3'd2,
    PCG_OFF     = 3'd3,
    PCG_UNGATE  = 3'd4
  } pcg_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/peripheral_idle_filter.sv
// Qualifies periph_idle: asserts once the input has been high on two consecutive sampled cycles.
module peripheral_idle_filter (
  input  logic clock,
  input  logic async_resetn,
  input  logic clear,
  input  logic in,
  output logic qualified
);

  logic seen_reg;

  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      seen_reg <= 1'b0;
    end else if (clear) begin
      seen_reg <= 1'b0;
    end else begin
      seen_reg <= in;
    end
  end

  // The current sample together with the previous one forms the two-cycle window.
  assign qualified = in & seen_reg & ~clear;

endmodule

// File: rtl/peripheral_clock_gate_sequencer.sv
// Sequences a peripheral through drain, clock gating and ungating under power-node stop/start requests.
module peripheral_clock_gate_sequencer
  import peripheral_power_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int GATE_SETTLE    = 4,
  parameter int UNGATE_SETTLE  = 8
) (
  input  logic clock,
  input  logic async_resetn,
  input  logic stop_req,
  input  logic start_req,
  input  logic periph_idle,
  input  logic err_clear,
  output logic quiesce_req,
  output logic clk_enable,
  output logic stopped,
  output logic started,
  output logic timeout_err
);

  localparam int CNT_MAX = max3(TIMEOUT_CYCLES, GATE_SETTLE, UNGATE_SETTLE);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Exits fire on the edge where the counter would reach the limit.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GATE_LAST    = CNT_W'(GATE_SETTLE - 1);
  localparam logic [CNT_W-1:0] UNGATE_LAST  = CNT_W'(UNGATE_SETTLE - 1);

  pcg_state_e       state_reg, state_next;
  logic [CNT_W-1:0] dwell_reg;
  logic             timeout_err_reg;
  logic             set_err;
  logic             idle_qualified;
  logic             filter_clear;

  assign filter_clear = (state_reg != PCG_QUIESCE);

  peripheral_idle_filter u_idle_filter (
    .clock        (clock),
    .async_resetn (async_resetn),
    .clear        (filter_clear),
    .in           (periph_idle),
    .qualified    (idle_qualified)
  );

  always_comb begin
    state_next = state_reg;
    set_err    = 1'b0;
    case (state_reg)
      PCG_RUN: begin
        if (stop_req) state_next = PCG_QUIESCE;
      end
      PCG_QUIESCE: begin
        // Abort outranks both the idle and the timeout exit.
        if (!stop_req) begin
          state_next = PCG_RUN;
        end else if (idle_qualified) begin
          state_next = PCG_GATE;
        end else if (dwell_reg >= TIMEOUT_LAST) begin
          state_next = PCG_GATE;
          set_err    = 1'b1;
        end
      end
      PCG_GATE: begin
        if (dwell_reg >= GATE_LAST) state_next = PCG_OFF;
      end
      PCG_OFF: begin
        if (start_req) state_next = PCG_UNGATE;
      end
      PCG_UNGATE: begin
        if (dwell_reg >= UNGATE_LAST) state_next = PCG_RUN;
      end
      default: state_next = PCG_OFF;
    endcase
  end

  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      state_reg <= PCG_OFF;
      dwell_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg) begin
        dwell_reg <= '0;
      end else if (dwell_reg != {CNT_W{1'b1}}) begin
        dwell_reg <= dwell_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      timeout_err_reg <= 1'b0;
    end else if (set_err) begin
      timeout_err_reg <= 1'b1;
    end else if (err_clear) begin
      timeout_err_reg <= 1'b0;
    end
  end

  assign quiesce_req = (state_reg == PCG_QUIESCE);
  assign clk_enable  = (state_reg == PCG_RUN) || (state_reg == PCG_QUIESCE) ||
                       (state_reg == PCG_UNGATE);
  assign stopped     = (state_reg == PCG_OFF);
  assign started     = (state_reg == PCG_RUN);
  assign timeout_err = timeout_err_reg;

endmodule
